// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared grant encoding and buffered write-back entry type.
package wb_arb_pkg;
    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_LOAD = 2'b01,
        GRANT_CORE = 2'b10
    } grant_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_hold_buffer.sv
// wb_hold_buffer: one-entry valid/ready holding register; drains and refills in the same cycle.
module wb_hold_buffer
    import wb_arb_pkg::*;
#(
    parameter type T = wb_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_valid,
    input  T     in_data,
    output logic in_ready,
    output logic out_valid,
    output T     out_data,
    input  logic take
);
    assign in_ready = en & (~out_valid | take);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            if (in_valid & in_ready) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else if (take) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the register-file write port between core results and load data.
// Optional WB_STATS_EN adds saturating conflict/promotion counters.
module writeback_arbiter
    import wb_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic              core_valid,
    input  logic [4:0]        core_rd,
    input  logic [31:0]       core_data,
    output logic              core_ready,
    input  logic              load_valid,
    input  logic [4:0]        load_rd,
    input  logic [31:0]       load_data,
    output logic              load_ready,
`ifdef WB_STATS_EN
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_conflicts,
    output logic [STAT_W-1:0] stat_promotions,
`endif
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata
);
    wb_entry_t core_q, load_q, win;
    logic      core_v, load_v, promote;
    logic [3:0] wait_cnt;
    grant_e    grant;

    wb_hold_buffer #(.T(wb_entry_t)) u_core_buf (
        .clk(clk), .rst(rst), .en(clk_enable),
        .in_valid(core_valid), .in_data('{rd: core_rd, data: core_data}), .in_ready(core_ready),
        .out_valid(core_v), .out_data(core_q), .take(grant == GRANT_CORE)
    );

    wb_hold_buffer #(.T(wb_entry_t)) u_load_buf (
        .clk(clk), .rst(rst), .en(clk_enable),
        .in_valid(load_valid), .in_data('{rd: load_rd, data: load_data}), .in_ready(load_ready),
        .out_valid(load_v), .out_data(load_q), .take(grant == GRANT_LOAD)
    );

    // A core result that has lost MAX_WAIT times in a row overrides load priority
    assign promote = core_v & (wait_cnt >= 4'(MAX_WAIT));

    always_comb begin
        grant = (load_v & ~promote) ? GRANT_LOAD : core_v ? GRANT_CORE : GRANT_NONE;
        win   = (grant == GRANT_LOAD) ? load_q : core_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (clk_enable) begin
            wait_cnt <= (~core_v | grant == GRANT_CORE) ? 4'd0 :
                        (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
            rf_we    <= (grant != GRANT_NONE) & (win.rd != REG_ZERO);
            if (grant != GRANT_NONE) begin
                rf_waddr <= win.rd;
                rf_wdata <= win.data;
            end
        end
    end

`ifdef WB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_conflicts  <= '0;
            stat_promotions <= '0;
        end else if (clk_enable) begin
            if (stat_clear) begin
                stat_conflicts  <= '0;
                stat_promotions <= '0;
            end else begin
                if (core_v & load_v & ~&stat_conflicts)
                    stat_conflicts <= stat_conflicts + 1'b1;
                if (grant == GRANT_CORE & load_v & promote & ~&stat_promotions)
                    stat_promotions <= stat_promotions + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vector table plus hand-written multi-cycle sequences.
module tb_writeback_arbiter;
    import wb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst, clk_enable, core_valid, load_valid;
    logic [4:0]  core_rd, load_rd, rf_waddr;
    logic [31:0] core_data, load_data, rf_wdata;
    logic        core_ready, load_ready, rf_we;
`ifdef WB_STATS_EN
    logic        stat_clear = 1'b0;
    logic [15:0] stat_conflicts, stat_promotions;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.MAX_WAIT(4), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable),
        .core_valid(core_valid), .core_rd(core_rd), .core_data(core_data), .core_ready(core_ready),
        .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data), .load_ready(load_ready),
`ifdef WB_STATS_EN
        .stat_clear(stat_clear), .stat_conflicts(stat_conflicts), .stat_promotions(stat_promotions),
`endif
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic        en, cv;
        logic [4:0]  crd;
        logic [31:0] cd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic        cr, lr;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic cv, input logic [4:0] crd, input logic [31:0] cd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        clk_enable = en; core_valid = cv; core_rd = crd; core_data = cd;
        load_valid = lv; load_rd = lrd; load_data = ld;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rf(input string n, input logic we, input logic [4:0] a, input logic [31:0] d);
        check({n, ".rf_we"}, 32'(rf_we), 32'(we));
        check({n, ".rf_waddr"}, 32'(rf_waddr), 32'(a));
        check({n, ".rf_wdata"}, rf_wdata, d);
    endtask

    task automatic rdy(input string n, input logic cr, input logic lr);
        check({n, ".core_ready"}, 32'(core_ready), 32'(cr));
        check({n, ".load_ready"}, 32'(load_ready), 32'(lr));
    endtask

    initial begin
        vt[0] = '{1, 1, 5, 32'h12345678, 0, 0, 0,            0, 0, 32'h0,        1, 1};
        vt[1] = '{1, 0, 0, 0,            0, 0, 0,            1, 5, 32'h12345678, 1, 1};
        vt[2] = '{1, 0, 0, 0,            0, 0, 0,            0, 5, 32'h12345678, 1, 1};
        vt[3] = '{1, 1, 8, 32'h0000BBBB, 1, 7, 32'hAAAA0000, 0, 5, 32'h12345678, 0, 1};
        vt[4] = '{1, 0, 0, 0,            0, 0, 0,            1, 7, 32'hAAAA0000, 1, 1};
        vt[5] = '{1, 0, 0, 0,            0, 0, 0,            1, 8, 32'h0000BBBB, 1, 1};
        vt[6] = '{1, 1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 8, 32'h0000BBBB, 1, 1};
        vt[7] = '{1, 0, 0, 0,            0, 0, 0,            0, 0, 32'hFFFFFFFF, 1, 1};
        vt[8] = '{1, 0, 0, 0,            0, 0, 0,            0, 0, 32'hFFFFFFFF, 1, 1};

        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        #12;
        rf("reset", 0, 0, 0);
        rst = 1'b0;
        #1;
        rdy("reset", 1, 1);

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].en, vt[i].cv, vt[i].crd, vt[i].cd, vt[i].lv, vt[i].lrd, vt[i].ld);
            tick();
            rf($sformatf("vec%0d", i), vt[i].we, vt[i].a, vt[i].d);
            rdy($sformatf("vec%0d", i), vt[i].cr, vt[i].lr);
        end

        // Starvation: core result waits behind back-to-back loads
`ifdef WB_STATS_EN
        stat_clear = 1'b1;
`endif
        drive(1, 1, 9, 32'h0000900D, 1, 10, 32'hD000000A);
        tick();
`ifdef WB_STATS_EN
        stat_clear = 1'b0;
`endif
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 0, 0, 1, 5'(10 + k), 32'hD0000000 | 32'(10 + k));
            #1;
            rdy($sformatf("starve%0d", k), 0, 1);
            tick();
            rf($sformatf("starve%0d", k), 1, 5'(9 + k), 32'hD0000000 | 32'(9 + k));
        end
        drive(1, 0, 0, 0, 1, 15, 32'hD000000F);
        #1;
        rdy("promote", 1, 0);
        tick();
        rf("promote", 1, 9, 32'h0000900D);
`ifdef WB_STATS_EN
        check("stat_promotions", 32'(stat_promotions), 1);
        check("stat_conflicts", 32'(stat_conflicts), 5);
`endif
        #1;
        rdy("after_promote", 1, 1);
        tick();
        rf("after_promote", 1, 14, 32'hD000000E);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        rf("held_load", 1, 15, 32'hD000000F);
        tick();
        rf("drained", 0, 15, 32'hD000000F);

        // clk_enable low with both buffers full and wait counter at 3
        drive(1, 1, 20, 32'h20, 1, 21, 32'd21);
        tick();
        rf("en_fill", 0, 15, 32'hD000000F);
        for (int r = 22; r <= 24; r++) begin
            drive(1, 0, 0, 0, 1, 5'(r), 32'(r));
            tick();
            rf($sformatf("en_load%0d", r), 1, 5'(r - 1), 32'(r - 1));
        end
        drive(0, 0, 0, 0, 1, 25, 32'd25);
        for (int c = 0; c < 3; c++) begin
            tick();
            rdy($sformatf("en_off%0d", c), 0, 0);
            rf($sformatf("en_off%0d", c), 1, 23, 32'd23);
        end
        drive(1, 0, 0, 0, 1, 25, 32'd25);
        #1;
        rdy("en_resume", 0, 1);
        tick();
        rf("en_resume", 1, 24, 32'd24);
        rdy("en_promote", 1, 0);
        tick();
        rf("en_promote", 1, 20, 32'h20);
        rdy("en_last", 1, 1);
        tick();
        rf("en_last", 1, 25, 32'd25);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset mid-transfer with both buffers holding entries
        drive(1, 1, 3, 32'h33, 1, 4, 32'h44);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        rf("pre_rst", 1, 4, 32'h44);
        #2;
        rst = 1'b1;
        #1;
        rf("mid_rst", 0, 0, 0);
        rdy("mid_rst", 1, 1);
        #2;
        rst = 1'b0;
        tick();
        rf("post_rst", 0, 0, 0);
        tick();
        rf("post_rst2", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
